regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (WE3/A3/WD3) between the in-order pipeline writeback stage and the multi-cycle MUL/DIV unit of the RV32IM core. It buffers completed MUL/DIV results in a small FIFO and drains them into free write-port cycles. It keeps a pending-destination scoreboard that stalls decode on RAW/WAW hazards against outstanding MUL/DIV ops. It sits between the WB stage, the MUL/DIV unit and the register file.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/wb_fifo.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// md_entry_t is one buffered MUL/DIV result waiting for a free write-port cycle.
package regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } md_entry_t;

  function automatic logic [REG_AW:0] popcount32(logic [31:0] v);
    logic [REG_AW:0] sum;
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + {{REG_AW{1'b0}}, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the WB-stage, MUL/DIV, decode and register-file write-port signals.
// master drives the pipeline side; slave is the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              md_valid;
  logic              md_ready;
  logic [REG_AW-1:0] md_rd;
  logic [XLEN-1:0]   md_data;

  logic              md_issue;
  logic [REG_AW-1:0] md_issue_rd;

  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic [REG_AW-1:0] dec_rd;

  logic              hz_stall;
  logic              wb_hold;

  logic              rf_we;
  logic [REG_AW-1:0] rf_a3;
  logic [XLEN-1:0]   rf_wd;

  logic [REG_AW:0]   pend_cnt;

  modport master (
    output wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, md_issue, md_issue_rd,
           dec_rs1, dec_rs2, dec_rd,
    input  md_ready, hz_stall, wb_hold, rf_we, rf_a3, rf_wd, pend_cnt
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, md_issue, md_issue_rd,
           dec_rs1, dec_rs2, dec_rd,
    output md_ready, hz_stall, wb_hold, rf_we, rf_a3, rf_wd, pend_cnt
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for MUL/DIV results with full/empty flags and a head passthrough.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  md_entry_t wdata,
  output md_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  md_entry_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB and the MUL/DIV result FIFO,
// tracks pending MUL/DIV destinations for hazard stalls and guards against FIFO starvation.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned CntW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] LimitC = CntW'(STARVE_LIMIT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic      push, pop, full, empty;
  md_entry_t head, wdata;

  logic [31:0]     pend_q, pend_d;
  logic [REG_AW:0] pend_cnt_q;
  logic [CntW-1:0] starve_q, starve_d;

  assign wdata = '{rd: bus.md_rd, data: bus.md_data};

  // x0 results are acknowledged but never buffered.
  assign push = bus.md_valid && !full && (bus.md_rd != REG_ZERO);
  assign pop  = rst_n && !bus.wb_we && !empty;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .wdata(wdata),
    .head (head),
    .full (full),
    .empty(empty)
  );

  assign bus.md_ready = !full;

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = '0;
    bus.rf_wd = '0;
    if (rst_n) begin
      if (bus.wb_we) begin
        bus.rf_we = 1'b1;
        bus.rf_a3 = bus.wb_rd;
        bus.rf_wd = bus.wb_data;
      end else if (!empty) begin
        bus.rf_we = 1'b1;
        bus.rf_a3 = head.rd;
        bus.rf_wd = head.data;
      end
    end
  end

  // Clear before set so a re-issue to the retiring rd stays pending.
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[head.rd] = 1'b0;
    if (bus.md_issue) pend_d[bus.md_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if (bus.wb_we && (starve_q < LimitC)) begin
      starve_d = starve_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
      starve_q   <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= popcount32(pend_d);
      starve_q   <= starve_d;
    end
  end

  assign bus.hz_stall = pend_q[bus.dec_rs1] | pend_q[bus.dec_rs2] | pend_q[bus.dec_rd];
  assign bus.wb_hold  = (starve_q >= LimitC);
  assign bus.pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic, each cycle checked
// against a queue/bit-array reference model of the sharing rules.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  typedef struct {
    int       rd;
    bit [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;

  ent_t q[$];
  bit   pend[32];
  int   starve;
  bit   last_acc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int npend();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(pend[i]);
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    starve   = 0;
    last_acc = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.wb_we = 0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.md_valid = 0; bus.md_rd = '0; bus.md_data = '0;
    bus.md_issue = 0; bus.md_issue_rd = '0;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
  endtask

  // Called at posedge+1 with inputs driven; checks mid-cycle, then advances one clock.
  task automatic tick();
    bit        exp_we, popped, was_full, was_empty;
    int        exp_a3;
    bit [31:0] exp_wd;
    #3;
    exp_we = 0; exp_a3 = 0; exp_wd = '0; popped = 0;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (bus.wb_we) begin
      exp_we = 1; exp_a3 = int'(bus.wb_rd); exp_wd = bus.wb_data;
    end else if (!was_empty) begin
      exp_we = 1; exp_a3 = q[0].rd; exp_wd = q[0].data; popped = 1;
    end
    chk("rf_we", 32'(bus.rf_we), 32'(exp_we));
    chk("rf_a3", 32'(bus.rf_a3), 32'(exp_a3));
    chk("rf_wd", bus.rf_wd, exp_wd);
    chk("md_ready", 32'(bus.md_ready), 32'(!was_full));
    chk("hz_stall", 32'(bus.hz_stall),
        32'(pend[bus.dec_rs1] | pend[bus.dec_rs2] | pend[bus.dec_rd]));
    chk("wb_hold", 32'(bus.wb_hold), 32'(starve >= LIMIT));
    chk("pend_cnt", 32'(bus.pend_cnt), 32'(npend()));
    if (popped) begin
      pend[q[0].rd] = 1'b0;
      void'(q.pop_front());
    end
    last_acc = bus.md_valid && !was_full;
    if (last_acc && bus.md_rd != 0) q.push_back('{rd: int'(bus.md_rd), data: bus.md_data});
    if (bus.md_issue && bus.md_issue_rd != 0) pend[bus.md_issue_rd] = 1'b1;
    if (popped || was_empty) starve = 0;
    else if (bus.wb_we) starve++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(string tag);
    #1;
    chk({tag, "_md_ready"}, 32'(bus.md_ready), 32'd1);
    chk({tag, "_hz_stall"}, 32'(bus.hz_stall), 32'd0);
    chk({tag, "_wb_hold"}, 32'(bus.wb_hold), 32'd0);
    chk({tag, "_pend_cnt"}, 32'(bus.pend_cnt), 32'd0);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
  endtask

  task automatic drain();
    idle_inputs();
    for (int c = 0; c < DEPTH + 2; c++) tick();
  endtask

  initial begin
    int k;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    reset_check("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Idle port: issue rd5, then deliver its result with the port free.
    bus.dec_rs1 = 5'd5;
    bus.md_issue = 1; bus.md_issue_rd = 5'd5;
    tick();
    bus.md_issue = 0;
    bus.md_valid = 1; bus.md_rd = 5'd5; bus.md_data = 32'h1234;
    tick();
    bus.md_valid = 0;
    for (int c = 0; c < 3; c++) tick();

    // Priority: one buffered result starved by WB until wb_hold forces a bubble.
    bus.dec_rs1 = '0;
    bus.wb_we = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'hAAAA_0003;
    bus.md_valid = 1; bus.md_rd = 5'd6; bus.md_data = 32'h6666;
    tick();
    bus.md_valid = 0;
    for (int c = 0; c < 8; c++) begin
      bus.wb_we = (starve >= LIMIT) ? 1'b0 : 1'b1;
      bus.wb_data = 32'hBEEF_0000 + 32'(c);
      tick();
    end

    // Full FIFO: three back-to-back results against a busy WB stage.
    k = 0;
    for (int c = 0; c < 24 && k < 3; c++) begin
      bus.wb_we = (starve >= LIMIT) ? 1'b0 : 1'b1;
      bus.md_valid = 1; bus.md_rd = 5'(10 + k); bus.md_data = 32'hC0DE_0000 + 32'(k);
      tick();
      if (last_acc) k++;
    end
    chk("full_accepts", 32'(k), 32'd3);
    drain();

    // x0 result is swallowed.
    bus.md_valid = 1; bus.md_rd = '0; bus.md_data = 32'hDEAD;
    tick();
    bus.md_valid = 0;
    tick();

    // Same-cycle set/clear on rd7: re-issue while the rd7 entry retires.
    bus.md_issue = 1; bus.md_issue_rd = 5'd7; bus.wb_we = 1;
    tick();
    bus.md_issue = 0;
    bus.md_valid = 1; bus.md_rd = 5'd7; bus.md_data = 32'h7777;
    tick();
    bus.md_valid = 0; bus.wb_we = 0;
    bus.md_issue = 1; bus.md_issue_rd = 5'd7;
    tick();
    bus.md_issue = 0; bus.dec_rs2 = 5'd7;
    tick();
    bus.dec_rs2 = '0;

    // WAW on rd9, and x0 operands never stall.
    bus.md_issue = 1; bus.md_issue_rd = 5'd9;
    tick();
    bus.md_issue = 0; bus.dec_rd = 5'd9;
    tick();
    bus.dec_rd = '0;
    tick();

    // Mid-operation reset with two buffered results and three pending bits.
    bus.wb_we = 1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2222;
    bus.md_valid = 1; bus.md_rd = 5'd11; bus.md_data = 32'hB11;
    bus.md_issue = 1; bus.md_issue_rd = 5'd12;
    tick();
    bus.md_issue = 0; bus.md_rd = 5'd13; bus.md_data = 32'hB13;
    tick();
    bus.md_valid = 0;
    tick();
    chk("pre_rst_pend", 32'(npend()), 32'd3);
    rst_n = 1'b0;
    reset_check("rst1");
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) tick();

    // Random traffic with a compliant pipeline and held md_valid.
    for (int c = 0; c < 400; c++) begin
      if (!bus.md_valid || last_acc) begin
        if ($urandom_range(0, 99) < 45) begin
          bus.md_valid = 1;
          bus.md_rd = 5'($urandom_range(0, 31));
          bus.md_data = $urandom;
        end else begin
          bus.md_valid = 0;
        end
      end
      bus.wb_we = (starve >= LIMIT) ? 1'b0 : 1'($urandom_range(0, 99) < 70);
      bus.wb_rd = 5'($urandom_range(0, 31));
      bus.wb_data = $urandom;
      bus.md_issue = 1'($urandom_range(0, 99) < 30);
      bus.md_issue_rd = 5'($urandom_range(0, 15));
      bus.dec_rs1 = 5'($urandom_range(0, 15));
      bus.dec_rs2 = 5'($urandom_range(0, 15));
      bus.dec_rd = 5'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
